// File: rtl/boot_rom_arbiter.sv
// Two-master arbiter for the single-port boot ROM: round-robin grant, address decode with
// range check, and a one-cycle registered response path carrying data or an error.
module boot_rom_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_8000,
    parameter int unsigned ROM_DEPTH = 548,
    parameter int unsigned ROM_AW    = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [1:0]        req_i,
    input  logic [31:0]       addr0_i,
    input  logic [31:0]       addr1_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        rvalid_o,
    output logic              rerr_o,
    output logic [31:0]       rdata_o,
    output logic              rom_csn_o,
    output logic [ROM_AW-1:0] rom_a_o,
    input  logic [31:0]       rom_q_i
);

    logic              rr_last_q;
    logic [1:0]        rvalid_q;
    logic              rerr_q;
    logic [31:0]       rdata_hold_q;
    logic [ROM_AW-1:0] rom_a_q;

    logic [1:0]        gnt;
    logic              sel;
    logic [31:0]       addr_sel;
    logic [31:0]       off;
    logic              in_range;
    logic              access;
    logic              unused_off;

    // A grant in a reset cycle is suppressed so nothing reaches the response pipeline.
    always_comb begin
        gnt = 2'b00;
        sel = 1'b0;
        if (!RST) begin
            if (req_i == 2'b11) begin
                sel = ~rr_last_q;
                gnt = sel ? 2'b10 : 2'b01;
            end else if (req_i[0]) begin
                sel = 1'b0;
                gnt = 2'b01;
            end else if (req_i[1]) begin
                sel = 1'b1;
                gnt = 2'b10;
            end
        end
    end

    assign addr_sel   = sel ? addr1_i : addr0_i;
    assign off        = addr_sel - BASE_ADDR;
    assign in_range   = (addr_sel >= BASE_ADDR) && (off[31:2] < 30'(ROM_DEPTH));
    assign access     = (|gnt) && in_range;
    assign unused_off = ^off[1:0];

    assign gnt_o     = gnt;
    assign rom_csn_o = ~access;
    assign rom_a_o   = RST ? '0 : (access ? off[ROM_AW+1:2] : rom_a_q);

    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_last_q    <= 1'b1;
            rvalid_q     <= 2'b00;
            rerr_q       <= 1'b0;
            rdata_hold_q <= 32'h0;
            rom_a_q      <= '0;
        end else begin
            if (|gnt) begin
                rr_last_q <= sel;
            end
            if (access) begin
                rom_a_q <= off[ROM_AW+1:2];
            end
            rvalid_q <= gnt;
            rerr_q   <= (|gnt) && !in_range;
            if (|rvalid_q) begin
                rdata_hold_q <= rdata_o;
            end
        end
    end

    // ROM data arrives the cycle after the address is presented, aligned with rvalid.
    always_comb begin
        rdata_o = rdata_hold_q;
        if (|rvalid_q) begin
            rdata_o = rerr_q ? 32'h0 : rom_q_i;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rerr_o   = rerr_q;

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Directed and constrained-random bench for boot_rom_arbiter with a registered ROM model.
module tb_boot_rom_arbiter;

    localparam logic [31:0] BASE = 32'h0000_8000;
    localparam int unsigned DEPTH = 548;

    logic        CLK;
    logic        RST;
    logic [1:0]  req_i;
    logic [31:0] addr0_i;
    logic [31:0] addr1_i;
    logic [1:0]  gnt_o;
    logic [1:0]  rvalid_o;
    logic        rerr_o;
    logic [31:0] rdata_o;
    logic        rom_csn_o;
    logic [9:0]  rom_a_o;
    logic [31:0] rom_q = 32'h0;

    int checks = 0;
    int errors = 0;

    boot_rom_arbiter #(
        .BASE_ADDR(BASE),
        .ROM_DEPTH(DEPTH),
        .ROM_AW(10)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .req_i(req_i),
        .addr0_i(addr0_i),
        .addr1_i(addr1_i),
        .gnt_o(gnt_o),
        .rvalid_o(rvalid_o),
        .rerr_o(rerr_o),
        .rdata_o(rdata_o),
        .rom_csn_o(rom_csn_o),
        .rom_a_o(rom_a_o),
        .rom_q_i(rom_q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] rom_word(input int unsigned i);
        if (i == 0) return 32'h0000_0013;
        if (i == 31) return 32'h0100_006F;
        return 32'hC0DE_0000 | i;
    endfunction

    always @(posedge CLK) begin
        if (!rom_csn_o) rom_q <= rom_word(32'(rom_a_o));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0: return $urandom;
            1: return BASE - 4 * $urandom_range(1, 8);
            2: return BASE + 4 * (DEPTH + $urandom_range(0, 10));
            default: return BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(0, 3);
        endcase
    endfunction

    function automatic logic addr_ok(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return (a >= BASE) && ((o >> 2) < DEPTH);
    endfunction

    initial begin
        int          cnt0;
        int          cnt1;
        logic        m_rr;
        logic [1:0]  rq;
        logic [1:0]  eg;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] pa;
        logic [31:0] last_data;
        logic [31:0] exp_data;
        logic        ir;
        logic        hold0;
        logic        hold1;

        RST = 1'b1;
        req_i = 2'b00;
        addr0_i = 32'h0;
        addr1_i = 32'h0;
        step();
        step();
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        chk("rst_rvalid", 32'(rvalid_o), 32'h0);
        chk("rst_rerr", 32'(rerr_o), 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_csn", 32'(rom_csn_o), 32'h1);
        chk("rst_rom_a", 32'(rom_a_o), 32'h0);
        RST = 1'b0;
        step();

        // Port 0 alone, word 0
        req_i = 2'b01;
        addr0_i = 32'h0000_8000;
        #1;
        chk("p0_gnt", 32'(gnt_o), 32'h1);
        chk("p0_rom_a", 32'(rom_a_o), 32'h0);
        chk("p0_csn", 32'(rom_csn_o), 32'h0);
        step();
        req_i = 2'b00;
        chk("p0_rvalid", 32'(rvalid_o), 32'h1);
        chk("p0_rerr", 32'(rerr_o), 32'h0);
        chk("p0_rdata", rdata_o, 32'h0000_0013);

        // Port 1 alone, unaligned byte address in word 31
        req_i = 2'b10;
        addr1_i = 32'h0000_807E;
        #1;
        chk("p1_gnt", 32'(gnt_o), 32'h2);
        chk("p1_rom_a", 32'(rom_a_o), 32'd31);
        step();
        req_i = 2'b00;
        #1;
        chk("p1_rvalid", 32'(rvalid_o), 32'h2);
        chk("p1_rdata", rdata_o, 32'h0100_006F);
        chk("idle_gnt", 32'(gnt_o), 32'h0);
        chk("idle_csn", 32'(rom_csn_o), 32'h1);
        chk("idle_rom_a_hold", 32'(rom_a_o), 32'd31);
        step();
        chk("idle_rvalid", 32'(rvalid_o), 32'h0);
        chk("idle_rdata_hold", rdata_o, 32'h0100_006F);

        // Continuous conflict: alternating grants, each port answered twice
        cnt0 = 0;
        cnt1 = 0;
        req_i = 2'b11;
        addr0_i = 32'h0000_8000;
        addr1_i = 32'h0000_8004;
        #1;
        chk("cf_gnt0", 32'(gnt_o), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) req_i = 2'b00;
            #1;
            if (rvalid_o[0]) cnt0++;
            if (rvalid_o[1]) cnt1++;
            chk("cf_rvalid", 32'(rvalid_o), (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("cf_rdata", rdata_o, (i % 2 == 0) ? 32'h0000_0013 : 32'hC0DE_0001);
            if (i < 3) chk("cf_gnt", 32'(gnt_o), (i % 2 == 0) ? 32'h2 : 32'h1);
        end
        chk("cf_cnt0", 32'(cnt0), 32'd2);
        chk("cf_cnt1", 32'(cnt1), 32'd2);

        // Out-of-range addresses and the last valid word
        req_i = 2'b01;
        addr0_i = 32'h0000_8890;
        #1;
        chk("oor_hi_gnt", 32'(gnt_o), 32'h1);
        chk("oor_hi_csn", 32'(rom_csn_o), 32'h1);
        step();
        addr0_i = 32'h0000_7FFC;
        chk("oor_hi_rvalid", 32'(rvalid_o), 32'h1);
        chk("oor_hi_rerr", 32'(rerr_o), 32'h1);
        chk("oor_hi_rdata", rdata_o, 32'h0);
        #1;
        chk("oor_lo_csn", 32'(rom_csn_o), 32'h1);
        step();
        addr0_i = 32'h0000_888C;
        chk("oor_lo_rerr", 32'(rerr_o), 32'h1);
        chk("oor_lo_rdata", rdata_o, 32'h0);
        #1;
        chk("last_csn", 32'(rom_csn_o), 32'h0);
        chk("last_rom_a", 32'(rom_a_o), 32'd547);
        step();
        req_i = 2'b00;
        chk("last_rvalid", 32'(rvalid_o), 32'h1);
        chk("last_rerr", 32'(rerr_o), 32'h0);
        chk("last_rdata", rdata_o, 32'hC0DE_0223);
        step();
        chk("rerr_clear", 32'(rerr_o), 32'h0);

        // Reset coincident with requests; round-robin pointer must return to port 0 first
        req_i = 2'b11;
        addr0_i = 32'h0000_8000;
        addr1_i = 32'h0000_8004;
        RST = 1'b1;
        step();
        RST = 1'b0;
        req_i = 2'b00;
        #1;
        chk("mrst_rvalid", 32'(rvalid_o), 32'h0);
        chk("mrst_csn", 32'(rom_csn_o), 32'h1);
        req_i = 2'b11;
        #1;
        chk("mrst_first_conflict", 32'(gnt_o), 32'h1);
        step();
        req_i = 2'b00;
        chk("mrst_resp", 32'(rvalid_o), 32'h1);
        step();

        // Random back-to-back traffic; losing requesters hold their request
        m_rr = 1'b0;
        hold0 = 1'b0;
        hold1 = 1'b0;
        a0 = 32'h0;
        a1 = 32'h0;
        rq = 2'b00;
        last_data = 32'h0000_0013;
        for (int n = 0; n < 300; n++) begin
            if (!hold0) begin
                rq[0] = 1'($urandom_range(0, 1));
                a0 = rand_addr();
            end
            if (!hold1) begin
                rq[1] = 1'($urandom_range(0, 1));
                a1 = rand_addr();
            end
            req_i = rq;
            addr0_i = a0;
            addr1_i = a1;
            #1;
            eg = (rq == 2'b11) ? (m_rr ? 2'b01 : 2'b10) : rq;
            ir = 1'b0;
            chk("rnd_gnt", 32'(gnt_o), 32'(eg));
            chk("rnd_gnt_onehot", 32'($onehot0(gnt_o)), 32'h1);
            if (eg != 2'b00) begin
                pa = eg[1] ? a1 : a0;
                ir = addr_ok(pa);
                m_rr = eg[1];
                chk("rnd_csn", 32'(rom_csn_o), 32'(!ir));
                if (ir) chk("rnd_rom_a", 32'(rom_a_o), (pa - BASE) >> 2);
            end
            hold0 = rq[0] && !eg[0];
            hold1 = rq[1] && !eg[1];
            step();
            chk("rnd_rvalid", 32'(rvalid_o), 32'(eg));
            chk("rnd_rvalid_onehot", 32'($onehot0(rvalid_o)), 32'h1);
            chk("rnd_rerr", 32'(rerr_o), 32'((eg != 2'b00) && !ir));
            exp_data = last_data;
            if (eg != 2'b00) exp_data = ir ? rom_word((pa - BASE) >> 2) : 32'h0;
            last_data = exp_data;
            chk("rnd_rdata", rdata_o, exp_data);
        end
        req_i = 2'b00;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
